// File: rtl/wb_slave_regfile_pkg.sv
// Shared Wishbone slave definitions: bus widths and FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// AW/DW/SELW size the bus, CW sizes the wait-state counter (WAIT_STATES <= 15).
// The state encodings are meant to be reused by later slaves on the same bus.
package wb_slave_regfile_pkg;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SELW = DW / 8;
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic single-beat bus between one master and one slave.
// Latency: n/a (wires only).
// Backpressure: the slave stalls the master by withholding s_ack_o / s_err_o.
//
// Signals keep the slave-side port names. s_err_o exists only when
// WB_SLAVE_ERR_EN is defined.
interface wb_slave_regfile_if;
    import wb_slave_regfile_pkg::*;

    logic            s_cyc_i;
    logic            s_stb_i;
    logic            s_we_i;
    logic [AW-1:0]   s_addr_i;
    logic [SELW-1:0] s_sel_i;
    logic [DW-1:0]   s_data_i;
    logic            s_ack_o;
    logic [DW-1:0]   s_data_o;
`ifdef WB_SLAVE_ERR_EN
    logic            s_err_o;
`endif

    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_sel_i, s_data_i,
`ifdef WB_SLAVE_ERR_EN
        input  s_err_o,
`endif
        input  s_ack_o, s_data_o
    );

    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_sel_i, s_data_i,
`ifdef WB_SLAVE_ERR_EN
        output s_err_o,
`endif
        output s_ack_o, s_data_o
    );

endinterface

// File: rtl/wb_bytemask_reg.sv
// One DW-bit register with an independent write enable per byte lane.
// Latency: written lanes visible on rd_dat the cycle after the write edge.
// Backpressure: none; a write is accepted on every edge its lane enable is set.
//
// Ports: clk_i, rst_i (sync, active-high), wr_en (one bit per byte lane),
// wr_dat (write data), rd_dat (current register contents).
module wb_bytemask_reg #(
    parameter int DW   = 32,
    parameter int SELW = DW / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SELW-1:0] wr_en,
    input  logic [DW-1:0]   wr_dat,
    output logic [DW-1:0]   rd_dat
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_dat <= '0;
        end else begin
            for (int k = 0; k < SELW; k++) begin
                if (wr_en[k]) begin
                    rd_dat[8*k +: 8] <= wr_dat[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave terminating single-beat transfers on a bank of NREGS registers.
// Latency: ack (or err) high in the cycle after edge E0+WAIT_STATES; WAIT_STATES+1 clocks.
// Backpressure: holds the master with wait states; one transfer per WAIT_STATES+2 cycles.
//
// Ports: clk_i, rst_i (sync, active-high), s (wb_slave_regfile_if.slave: cyc/stb/we/addr/
// sel/data in, registered ack/data out, registered err out with WB_SLAVE_ERR_EN).
// Optional feature macro WB_SLAVE_ERR_EN: an address miss terminates with s_err_o instead
// of s_ack_o, drops the write and leaves s_data_o untouched. Without it a miss is acked,
// writes are ignored and reads return 0.
module wb_slave_regfile
    import wb_slave_regfile_pkg::*;
#(
    parameter logic [AW-1:0] slave_address = '0,
    parameter int            NREGS         = 4,
    parameter int            WAIT_STATES   = 1
) (
    input logic               clk_i,
    input logic               rst_i,
    wb_slave_regfile_if.slave s
);

    localparam int IW = $clog2(NREGS);
    // Counter preload; the WAIT state runs WAIT_STATES cycles counting down to 0.
    localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

    wb_state_e       state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            req, hit, go_ack, wr_hit;
    logic [IW-1:0]   reg_idx;
    logic [DW-1:0]   regs_q [NREGS];
    logic            ack_q;
    logic [DW-1:0]   data_q;

    assign req     = s.s_cyc_i & s.s_stb_i;
    assign hit     = (s.s_addr_i[AW-1:IW] == slave_address[AW-1:IW]);
    assign reg_idx = s.s_addr_i[IW-1:0];
    // The access itself happens on the edge that enters ACK.
    assign wr_hit  = go_ack & s.s_we_i & hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WB_S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        go_ack    = 1'b0;
        case (state_q)
            WB_S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = WB_S_ACK;
                        go_ack    = 1'b1;
                    end else begin
                        cnt_nxt   = WS_LOAD;
                        state_nxt = WB_S_WAIT;
                    end
                end
            end
            WB_S_WAIT: begin
                if (!req) begin
                    // Master gave up: abort with no access and no termination.
                    state_nxt = WB_S_IDLE;
                end else if (cnt_q == '0) begin
                    state_nxt = WB_S_ACK;
                    go_ack    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            WB_S_ACK:  state_nxt = WB_S_IDLE;
            default:   state_nxt = WB_S_IDLE;
        endcase
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        logic [SELW-1:0] lane_we;
        assign lane_we = (wr_hit && reg_idx == IW'(g)) ? s.s_sel_i : '0;

        wb_bytemask_reg #(
            .DW   (DW),
            .SELW (SELW)
        ) u_reg (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .wr_en  (lane_we),
            .wr_dat (s.s_data_i),
            .rd_dat (regs_q[g])
        );
    end

`ifdef WB_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q <= go_ack & hit;
            err_q <= go_ack & ~hit;
            // A missed read keeps the previous read data.
            if (go_ack && !s.s_we_i && hit) begin
                data_q <= regs_q[reg_idx];
            end
        end
    end

    assign s.s_err_o = err_q;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q <= go_ack;
            if (go_ack && !s.s_we_i) begin
                data_q <= hit ? regs_q[reg_idx] : '0;
            end
        end
    end
`endif

    assign s.s_ack_o  = ack_q;
    assign s.s_data_o = data_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: NREGS=4, WAIT_STATES=2, base 0x100.
// Latency: expects termination WAIT_STATES+1 = 3 clocks after the first strobe edge.
// Backpressure: the bench master holds cyc/stb until it sees ack or err.
module tb_wb_slave_regfile;
    import wb_slave_regfile_pkg::*;

    localparam int WS = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    wb_slave_regfile_if bus ();

    wb_slave_regfile #(
        .slave_address (32'h0000_0100),
        .NREGS         (4),
        .WAIT_STATES   (WS)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .s     (bus.slave)
    );

    function automatic logic err_now();
`ifdef WB_SLAVE_ERR_EN
        return bus.s_err_o;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.s_cyc_i  = 1'b0;
        bus.s_stb_i  = 1'b0;
        bus.s_we_i   = 1'b0;
        bus.s_addr_i = '0;
        bus.s_sel_i  = '0;
        bus.s_data_i = '0;
    endtask

    // One transfer; lat = number of clocks from the first strobe edge to the
    // edge that samples the termination (-1 on timeout).
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdat, output int lat, output logic got_ack,
                        output logic got_err, output logic [31:0] rdat);
        lat = -1;
        got_ack = 1'b0;
        got_err = 1'b0;
        rdat = '0;
        @(negedge clk_i);
        bus.s_cyc_i  = 1'b1;
        bus.s_stb_i  = 1'b1;
        bus.s_we_i   = we;
        bus.s_addr_i = addr;
        bus.s_sel_i  = sel;
        bus.s_data_i = wdat;
        @(posedge clk_i);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (bus.s_ack_o || err_now()) begin
                lat = n;
                got_ack = bus.s_ack_o;
                got_err = err_now();
                rdat = bus.s_data_o;
                break;
            end
            @(posedge clk_i);
        end
        drive_idle();
        @(negedge clk_i);
        check("term_one_cycle", {31'd0, bus.s_ack_o | err_now()}, 32'd0);
    endtask

    int          lat;
    logic        a, e;
    logic [31:0] rd;
    int          ack_at [3];
    int          n_acks;

    initial begin
        drive_idle();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ack", {31'd0, bus.s_ack_o}, 32'd0);
        check("rst_data", bus.s_data_o, 32'd0);
        check("rst_err", {31'd0, err_now()}, 32'd0);
        rst_i = 1'b0;

        // Full write then read back.
        xfer(1'b1, 32'h101, 4'hF, 32'hDEADBEEF, lat, a, e, rd);
        check("wr101_lat", 32'(lat), 32'd3);
        check("wr101_ack", {31'd0, a}, 32'd1);
        xfer(1'b0, 32'h101, 4'h0, 32'h0, lat, a, e, rd);
        check("rd101_lat", 32'(lat), 32'd3);
        check("rd101_data", rd, 32'hDEADBEEF);

        // Byte-lane write over a preloaded value.
        xfer(1'b1, 32'h102, 4'hF, 32'h11223344, lat, a, e, rd);
        xfer(1'b1, 32'h102, 4'b0101, 32'hAABBCCDD, lat, a, e, rd);
        xfer(1'b0, 32'h102, 4'h0, 32'h0, lat, a, e, rd);
        check("rd102_lanes", rd, 32'h11BB33DD);

        // Strobe to 0x103 for 2 cycles, then abort.
        @(negedge clk_i);
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = 1'b1;
        bus.s_addr_i = 32'h103; bus.s_sel_i = 4'hF; bus.s_data_i = 32'hFFFFFFFF;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_ack_c1", {31'd0, bus.s_ack_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_ack_c2", {31'd0, bus.s_ack_o}, 32'd0);
        drive_idle();
        repeat (3) begin
            @(negedge clk_i);
            check("abort_no_ack", {31'd0, bus.s_ack_o}, 32'd0);
        end
        xfer(1'b0, 32'h103, 4'h0, 32'h0, lat, a, e, rd);
        check("after_abort_lat", 32'(lat), 32'd3);
        check("reg3_unchanged", rd, 32'h0);

        // Back-to-back reads of 0x100 under continuous strobe.
        xfer(1'b1, 32'h100, 4'hF, 32'h12345678, lat, a, e, rd);
        @(negedge clk_i);
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = 1'b0;
        bus.s_addr_i = 32'h100;
        n_acks = 0;
        for (int c = 1; c <= 30 && n_acks < 3; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (bus.s_ack_o) begin
                ack_at[n_acks] = c;
                check("b2b_data", bus.s_data_o, 32'h12345678);
                n_acks++;
            end
        end
        drive_idle();
        check("b2b_count", 32'(n_acks), 32'd3);
        if (n_acks == 3) begin
            check("b2b_first", 32'(ack_at[0]), 32'd3);
            check("b2b_gap1", 32'(ack_at[1] - ack_at[0]), 32'd4);
            check("b2b_gap2", 32'(ack_at[2] - ack_at[1]), 32'd4);
        end
        @(negedge clk_i);

        // Address miss.
        xfer(1'b0, 32'h200, 4'h0, 32'h0, lat, a, e, rd);
        check("miss_lat", 32'(lat), 32'd3);
`ifdef WB_SLAVE_ERR_EN
        check("miss_err", {31'd0, e}, 32'd1);
        check("miss_no_ack", {31'd0, a}, 32'd0);
        check("miss_data_held", rd, 32'h12345678);
`else
        check("miss_ack", {31'd0, a}, 32'd1);
        check("miss_data", rd, 32'h0);
`endif

        // Reset during the WAIT phase of a write.
        @(negedge clk_i);
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = 1'b1;
        bus.s_addr_i = 32'h100; bus.s_sel_i = 4'hF; bus.s_data_i = 32'h5A5A5A5A;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_idle();
        check("rst_mid_ack", {31'd0, bus.s_ack_o}, 32'd0);
        check("rst_mid_data", bus.s_data_o, 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            check("rst_mid_no_ack", {31'd0, bus.s_ack_o}, 32'd0);
        end
        for (int r = 0; r < 4; r++) begin
            xfer(1'b0, 32'h100 + 32'(r), 4'h0, 32'h0, lat, a, e, rd);
            check("rst_reg_lat", 32'(lat), 32'd3);
            check("rst_reg_zero", rd, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
